// File: rtl/alu_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// alu_ctrl_decode_stage : RV32I OP/OP-IMM/LUI/AUIPC decode into ALU controls
// Rev 1.0
// ============================================================================
module alu_ctrl_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        illegal
);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_PASS = 4'b1111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic        r_valid;
  logic [3:0]  r_sel;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [4:0]  r_rd;
  logic        r_we;
  logic        r_ill;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [3:0]  w_sel;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_ill;
  logic        w_we;
  logic        w_accept;

  assign w_opcode = inst[6:0];
  assign w_f3     = inst[14:12];
  assign w_f7     = inst[31:25];
  assign w_rd     = inst[11:7];

  always_comb begin
    w_sel = SEL_ADD;
    w_op1 = 32'd0;
    w_op2 = 32'd0;
    w_ill = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_sel = {inst[30], w_f3};
        w_op1 = rs1_data;
        w_op2 = rs2_data;
        w_ill = !((w_f7 == F7_ZERO) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        w_sel = {(w_f3 == 3'b101) ? inst[30] : 1'b0, w_f3};
        w_op1 = rs1_data;
        w_op2 = {{20{inst[31]}}, inst[31:20]};
        case (w_f3)
          3'b001:  w_ill = (w_f7 != F7_ZERO);
          3'b101:  w_ill = !((w_f7 == F7_ZERO) || (w_f7 == F7_ALT));
          default: w_ill = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_sel = SEL_PASS;
        w_op2 = {inst[31:12], 12'd0};
        w_ill = 1'b0;
      end
      OPC_AUIPC: begin
        w_sel = SEL_ADD;
        w_op1 = pc;
        w_op2 = {inst[31:12], 12'd0};
        w_ill = 1'b0;
      end
      default: w_ill = 1'b1;
    endcase
    // Every illegal encoding presents the same neutral bundle to the ALU.
    if (w_ill) begin
      w_sel = SEL_ADD;
      w_op1 = 32'd0;
      w_op2 = 32'd0;
    end
  end

  assign w_we     = !w_ill && (w_rd != 5'd0);
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sel   <= 4'd0;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_rd    <= 5'd0;
      r_we    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_sel   <= w_sel;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_rd    <= w_rd;
      r_we    <= w_we;
      r_ill   <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign alu_sel   = r_sel;
  assign operand1  = r_op1;
  assign operand2  = r_op2;
  assign rd        = r_rd;
  assign reg_we    = r_we;
  assign illegal   = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl_decode_stage : directed vector bench for alu_ctrl_decode_stage
// Rev 1.0
// ============================================================================
module tb_alu_ctrl_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  rd;
  logic        reg_we;
  logic        illegal;

  alu_ctrl_decode_stage u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_sel   (alu_sel),
    .operand1  (operand1),
    .operand2  (operand2),
    .rd        (rd),
    .reg_we    (reg_we),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_pass   = 0;

  // bundle = {alu_sel, operand1, operand2, rd, reg_we, illegal}
  function automatic logic [74:0] bundle_now();
    return {alu_sel, operand1, operand2, rd, reg_we, illegal};
  endfunction

  function automatic logic [74:0] bundle_exp(vec_t v);
    return {v.sel, v.op1, v.op2, v.rd, v.we, v.ill};
  endfunction

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input logic vld);
    inst     = v.inst;
    pc       = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    in_valid = vld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            inst          pc            rs1           rs2           sel    op1           op2           rd  we ill
    vecs[0]  = '{32'h002081B3, 32'h0,       32'd5,        32'd7,        4'h0, 32'd5,        32'd7,        5'd3, 1, 0};
    vecs[1]  = '{32'h402081B3, 32'h0,       32'd5,        32'd7,        4'h8, 32'd5,        32'd7,        5'd3, 1, 0};
    vecs[2]  = '{32'h4020F1B3, 32'h0,       32'd5,        32'd7,        4'h0, 32'd0,        32'd0,        5'd3, 0, 1};
    vecs[3]  = '{32'h40435293, 32'h0,       32'h80000000, 32'd9,        4'hD, 32'h80000000, 32'h00000404, 5'd5, 1, 0};
    vecs[4]  = '{32'h00100013, 32'h0,       32'd0,        32'd0,        4'h0, 32'd0,        32'd1,        5'd0, 0, 0};
    vecs[5]  = '{32'h123450B7, 32'h0,       32'hDEAD,     32'hBEEF,     4'hF, 32'd0,        32'h12345000, 5'd1, 1, 0};
    vecs[6]  = '{32'h00001097, 32'h100,     32'hDEAD,     32'hBEEF,     4'h0, 32'h100,      32'h1000,     5'd1, 1, 0};
    vecs[7]  = '{32'h0000007F, 32'h40,      32'd1,        32'd2,        4'h0, 32'd0,        32'd0,        5'd0, 0, 1};
    vecs[8]  = '{32'hFFF1C113, 32'h0,       32'hA5,       32'd0,        4'h4, 32'hA5,       32'hFFFFFFFF, 5'd2, 1, 0};
    vecs[9]  = '{32'h02109093, 32'h0,       32'd3,        32'd0,        4'h0, 32'd0,        32'd0,        5'd1, 0, 1};
    vecs[10] = '{32'h4020D1B3, 32'h0,       32'd5,        32'd7,        4'hD, 32'd5,        32'd7,        5'd3, 1, 0};
    vecs[11] = '{32'h00000031, 32'h0,       32'd5,        32'd7,        4'h0, 32'd0,        32'd0,        5'd0, 0, 1};
    vecs[12] = '{32'h0020B233, 32'h0,       32'd11,       32'd12,       4'h3, 32'd11,       32'd12,       5'd4, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    tick();
    chk("reset_valid", {74'd0, out_valid}, 75'd0);
    chk("reset_bundle", bundle_now(), 75'd0);
    chk("reset_in_ready", {74'd0, in_ready}, 75'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), {74'd0, out_valid}, 75'd1);
      chk($sformatf("vec%0d_bundle", i), bundle_now(), bundle_exp(vecs[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_empty", {74'd0, out_valid}, 75'd0);

    // Backpressure: A held for 3 clocks while B waits, then drain+accept together.
    out_ready = 1'b0;
    drive(vecs[0], 1'b1);
    tick();
    chk("hold_load_valid", {74'd0, out_valid}, 75'd1);
    drive(vecs[5], 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_in_ready", k), {74'd0, in_ready}, 75'd0);
      tick();
      chk($sformatf("hold%0d_valid", k), {74'd0, out_valid}, 75'd1);
      chk($sformatf("hold%0d_bundle", k), bundle_now(), bundle_exp(vecs[0]));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {74'd0, in_ready}, 75'd1);
    tick();
    chk("swap_valid", {74'd0, out_valid}, 75'd1);
    chk("swap_bundle", bundle_now(), bundle_exp(vecs[5]));
    in_valid = 1'b0;
    tick();
    chk("swap_drained", {74'd0, out_valid}, 75'd0);

    // Flush kills the held bundle and the concurrent input.
    out_ready = 1'b0;
    drive(vecs[1], 1'b1);
    tick();
    chk("pre_flush_valid", {74'd0, out_valid}, 75'd1);
    drive(vecs[3], 1'b1);
    flush = 1'b1;
    tick();
    chk("flush_valid", {74'd0, out_valid}, 75'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post_flush_valid", {74'd0, out_valid}, 75'd0);

    // Asynchronous reset while holding.
    drive(vecs[0], 1'b1);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {74'd0, out_valid}, 75'd0);
    chk("async_rst_bundle", bundle_now(), 75'd0);
    #2;
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
